act_requant: RTL and testbench
==============================

# act_requant

Post-multiply activation and requantization stage sitting directly downstream of the matrix-vector multiplier. On a start pulse aligned with the multiplier's done, it captures the full row-result vector and a bias vector. It then streams one requantized element per cycle over a valid/ready handshake to the next layer's input buffer. Each element goes through bias add, arithmetic right shift, activation, and saturation.

## Interface
- ROWS, 6, number of elements in the captured vector
- IN_WIDTH, 16, signed width of each incoming accumulator element and each bias element
- OUT_WIDTH, 8, signed width of each output element
- SHIFT, 2, arithmetic right-shift amount applied after bias add (0 to IN_WIDTH)

- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle capture pulse, driven by upstream done
- in_vector  input  ROWS*IN_WIDTH  signed elements; element 0 in the most significant slice
- bias  input  ROWS*IN_WIDTH  signed per-element bias, same ordering
- out_data  output  OUT_WIDTH  current requantized element
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  downstream accepts out_data when high with out_valid
- out_last  output  1  high with out_valid on element ROWS-1
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, PREP, STREAM.
- IDLE:
  - start=1 captures in_vector and bias into internal registers, clears idx, and moves to PREP.
  - start=0 stays in IDLE.
- PREP:
  - out_data is loaded with element 0 and out_valid is set.
  - Moves to STREAM unconditionally.
- STREAM, on a handshake (out_valid && out_ready):
  - idx<ROWS-1: idx increments, out_data loads element idx+1, out_valid stays high.
  - idx==ROWS-1: out_valid and out_last drop, and the state moves to IDLE.
- STREAM, no handshake: out_data, out_valid and out_last hold stable.
- Element arithmetic:
  - Bias add: sum = sext(in[i]) + sext(bias[i]), computed in IN_WIDTH+1 bits so no overflow.
  - Shift: sum >>> SHIFT, an arithmetic floor shift.
  - Activation: see Configuration.
  - Saturation: clamp to the OUT_WIDTH signed range.
- start is ignored while busy=1. The captured data is unaffected and no error is flagged.
- out_last = out_valid && (idx == ROWS-1).

## Timing
- Reset: state returns to IDLE. out_valid=0, out_last=0, busy=0, out_data=0, idx=0, capture registers=0.
- Latency:
  - start sampled at edge N.
  - out_valid is first high after edge N+1, the PREP edge.
- Throughput: one element per cycle with out_ready held high. Total transfer is ROWS cycles after the first valid.
- Back-to-back vectors: a start in the IDLE cycle immediately after the last handshake is accepted, giving a minimum 2-cycle gap between vectors.
- out_ready high while out_valid is low has no effect.
- reset asserted mid-stream returns the block to IDLE at that edge. out_valid is low the next cycle and no partial elements follow.
- start coinciding with reset: reset wins and nothing is captured.
- ROWS=1: element 0 carries out_last in its first valid cycle.

## Configuration
- ACT_RELU_EN defined: ReLU is applied before saturation.
  - Negative shifted values output 0.
  - The output range is [0, 2^(OUT_WIDTH-1)-1].
- ACT_RELU_EN undefined: the activation is linear.
  - Values saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Negative results are output in two's complement.

## Structure
- Shared package act_pkg holds:
  - the state encoding localparams: IDLE=2'b00, PREP=2'b01, STREAM=2'b10;
  - the saturation limit constants, expressed as functions of OUT_WIDTH.
- Sub-module act_lane is purely combinational, one instance.
  - Inputs: one IN_WIDTH element and one bias.
  - Output: one OUT_WIDTH result.
  - Function: bias add, shift, activation and saturation.
  - It is fed by an idx-selected slice mux. The FSM, index counter and output register live in act_requant.

## Test plan
Settings for scenarios 1-4: ROWS=3, IN_WIDTH=16, OUT_WIDTH=8, SHIFT=2, ACT_RELU_EN defined.
1. Basic stream:
   - Stimulus: in={100,-40,2000}, bias={4,0,0}, start pulse, out_ready=1.
   - Required: outputs 26, 0, 127 on consecutive cycles. First valid is 2 cycles after start. out_last on the third output only. busy low afterwards.
2. Backpressure:
   - Stimulus: same data; out_ready toggles 1,0,0,1,0,1.
   - Required: each element is held stable while out_ready=0. Exactly 3 handshakes, values unchanged.
3. Start while busy:
   - Stimulus: second start with in={8,8,8} asserted during STREAM.
   - Required: the stream still outputs 26, 0, 127. No extra elements.
4. Reset mid-stream:
   - Stimulus: reset asserted after the first handshake.
   - Required: out_valid=0, busy=0 and out_data=0 on the next cycle. A new start then produces a full fresh 3-element stream.
5. ACT_RELU_EN undefined:
   - Stimulus: in={-40,-4000,300}, bias=0.
   - Required outputs, in order:
     - 0xF6 (-10);
     - 0x80 (-128, saturated);
     - 0x4B (75).
6. Back-to-back vectors:
   - Stimulus: start issued in the first IDLE cycle after the last handshake.
   - Required: the second vector is captured. Its first valid arrives 2 cycles later with correct values.

Source files
------------

// File: rtl/act_pkg.sv
// Shared types and saturation helpers for the activation/requantization stage.
package act_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PREP   = 2'b01,
    STREAM = 2'b10
  } state_t;

  // Largest value representable in a w-bit signed word
  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit signed word
  function automatic int sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/act_lane.sv
// One requantization lane: bias add, arithmetic shift, activation, saturation.
// Define ACT_RELU_EN to apply ReLU before saturation; otherwise the lane is linear.
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SHIFT     = 2
) (
  input  logic [IN_WIDTH-1:0]  elem,
  input  logic [IN_WIDTH-1:0]  bias,
  output logic [OUT_WIDTH-1:0] result_c
);

  localparam int unsigned SW = IN_WIDTH + 1;
  localparam logic signed [SW-1:0] HI = SW'(sat_max(OUT_WIDTH));
  localparam logic signed [SW-1:0] LO = SW'(sat_min(OUT_WIDTH));

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] act;

  // One guard bit keeps the bias add overflow-free
  assign sum     = $signed({elem[IN_WIDTH-1], elem}) + $signed({bias[IN_WIDTH-1], bias});
  assign shifted = sum >>> SHIFT;

  // Activation then clamp into the signed output range
  always_comb begin
    act = shifted;
`ifdef ACT_RELU_EN
    if (shifted[SW-1]) act = '0;
`endif
    if (act > HI)      result_c = OUT_WIDTH'(HI);
    else if (act < LO) result_c = OUT_WIDTH'(LO);
    else               result_c = act[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/act_requant.sv
// Captures a row-result vector plus bias and streams requantized elements over valid/ready.
// Activation mode selected by ACT_RELU_EN (see act_lane).
module act_requant
  import act_pkg::*;
#(
  parameter int unsigned ROWS      = 6,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SHIFT     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROWS*IN_WIDTH-1:0] in_vector,
  input  logic [ROWS*IN_WIDTH-1:0] bias,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy
);

  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SEL_W = IDX_W + 1;
  localparam int unsigned VEC_W = ROWS * IN_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [VEC_W-1:0]      vec_q;
  logic [VEC_W-1:0]      bias_q;
  logic [SEL_W-1:0]      sel_c;
  logic [IN_WIDTH-1:0]   elem_c;
  logic [IN_WIDTH-1:0]   bias_c;
  logic [OUT_WIDTH-1:0]  lane_c;
  logic                  handshake_c;

  assign handshake_c = out_valid && out_ready;

  // In STREAM the lane precomputes the element to load on the next handshake
  always_comb begin
    sel_c = {1'b0, idx};
    if (state == STREAM) sel_c = sel_c + SEL_W'(1);
  end

  // Element 0 sits in the most significant slice
  always_comb begin
    elem_c = '0;
    bias_c = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      if (sel_c == SEL_W'(i)) begin
        elem_c = vec_q[(int'(ROWS) - 1 - i) * int'(IN_WIDTH) +: IN_WIDTH];
        bias_c = bias_q[(int'(ROWS) - 1 - i) * int'(IN_WIDTH) +: IN_WIDTH];
      end
    end
  end

  act_lane #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_lane (
    .elem    (elem_c),
    .bias    (bias_c),
    .result_c(lane_c)
  );

  // Capture / prepare / stream control with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      vec_q     <= '0;
      bias_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_q  <= in_vector;
            bias_q <= bias;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          out_data  <= lane_c;
          out_valid <= 1'b1;
          out_last  <= (LAST_IDX == '0);
          state     <= STREAM;
        end
        STREAM: begin
          if (handshake_c) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              idx      <= idx + IDX_W'(1);
              out_data <= lane_c;
              out_last <= ((idx + IDX_W'(1)) == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_requant.sv
// Directed bench for act_requant with ROWS=3; expectations follow the ACT_RELU_EN setting.
module tb_act_requant;

  localparam int unsigned ROWS = 3;
  localparam int unsigned IW   = 16;
  localparam int unsigned OW   = 8;

  localparam logic [15:0] M40   = 16'hFFD8; // -40
  localparam logic [15:0] M4000 = 16'hF060; // -4000

  localparam logic [47:0] VEC_A  = {16'd100, M40, 16'd2000};
  localparam logic [47:0] BIAS_A = {16'd4, 16'd0, 16'd0};
  localparam logic [47:0] VEC_B  = {M40, M4000, 16'd300};
  localparam logic [47:0] VEC_8  = {16'd8, 16'd8, 16'd8};

  localparam logic [7:0] A0 = 8'd26;
  localparam logic [7:0] A2 = 8'd127;
  localparam logic [7:0] B2 = 8'h4B;
`ifdef ACT_RELU_EN
  localparam logic [7:0] A1 = 8'h00;
  localparam logic [7:0] B0 = 8'h00;
  localparam logic [7:0] B1 = 8'h00;
`else
  localparam logic [7:0] A1 = 8'hF6;
  localparam logic [7:0] B0 = 8'hF6;
  localparam logic [7:0] B1 = 8'h80;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [ROWS*IW-1:0] in_vector;
  logic [ROWS*IW-1:0] bias;
  logic [OW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;

  int n_cmp  = 0;
  int n_fail = 0;

  act_requant #(.ROWS(ROWS), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_vector(in_vector),
    .bias     (bias),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".last"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    in_vector = VEC_A; bias = BIAS_A;
    tick(); tick();
    reset = 1'b0;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.last", 32'(out_last), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);

    // 1: basic stream
    out_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("s1.prep_valid", 32'(out_valid), 32'd0);
    chk("s1.busy", 32'(busy), 32'd1);
    tick(); chk_out("s1.e0", 1'b1, A0, 1'b0);
    tick(); chk_out("s1.e1", 1'b1, A1, 1'b0);
    tick(); chk_out("s1.e2", 1'b1, A2, 1'b1);
    tick(); chk_out("s1.end", 1'b0, 8'h00, 1'b0);
    chk("s1.busy_end", 32'(busy), 32'd0);

    // 2: backpressure, ready pattern 1,0,0,1,0,1 across the valid window
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk_out("s2.e0", 1'b1, A0, 1'b0);
    out_ready = 1'b0;
    tick(); chk_out("s2.hold0a", 1'b1, A0, 1'b0);
    tick(); chk_out("s2.hold0b", 1'b1, A0, 1'b0);
    out_ready = 1'b1;
    tick(); chk_out("s2.e1", 1'b1, A1, 1'b0);
    out_ready = 1'b0;
    tick(); chk_out("s2.hold1", 1'b1, A1, 1'b0);
    out_ready = 1'b1;
    tick(); chk_out("s2.e2", 1'b1, A2, 1'b1);
    out_ready = 1'b0;
    tick(); chk_out("s2.hold2", 1'b1, A2, 1'b1);
    out_ready = 1'b1;
    tick(); chk_out("s2.end", 1'b0, 8'h00, 1'b0);
    chk("s2.busy_end", 32'(busy), 32'd0);

    // 3: start while busy is ignored
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk_out("s3.e0", 1'b1, A0, 1'b0);
    start = 1'b1; in_vector = VEC_8;
    tick(); start = 1'b0;
    chk_out("s3.e1", 1'b1, A1, 1'b0);
    tick(); chk_out("s3.e2", 1'b1, A2, 1'b1);
    tick(); chk_out("s3.end", 1'b0, 8'h00, 1'b0);
    tick(); chk_out("s3.noextra", 1'b0, 8'h00, 1'b0);
    chk("s3.busy_idle", 32'(busy), 32'd0);
    in_vector = VEC_A;

    // 4: reset mid-stream, then a fresh stream
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk_out("s4.e0", 1'b1, A0, 1'b0);
    tick(); chk_out("s4.e1", 1'b1, A1, 1'b0);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("s4.rst_valid", 32'(out_valid), 32'd0);
    chk("s4.rst_busy", 32'(busy), 32'd0);
    chk("s4.rst_data", 32'(out_data), 32'd0);
    tick(); chk_out("s4.nopartial", 1'b0, 8'h00, 1'b0);
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk_out("s4.f0", 1'b1, A0, 1'b0);
    tick(); chk_out("s4.f1", 1'b1, A1, 1'b0);
    tick(); chk_out("s4.f2", 1'b1, A2, 1'b1);
    tick(); chk_out("s4.fend", 1'b0, 8'h00, 1'b0);

    // start coinciding with reset captures nothing
    reset = 1'b1; start = 1'b1;
    tick(); reset = 1'b0; start = 1'b0;
    tick();
    chk("s4.rststart_busy", 32'(busy), 32'd0);
    chk("s4.rststart_valid", 32'(out_valid), 32'd0);

    // 6 + 5: vector A, then vector B started in the first IDLE cycle
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk_out("s6.a0", 1'b1, A0, 1'b0);
    tick(); chk_out("s6.a1", 1'b1, A1, 1'b0);
    tick(); chk_out("s6.a2", 1'b1, A2, 1'b1);
    tick(); chk_out("s6.gap", 1'b0, 8'h00, 1'b0);
    start = 1'b1; in_vector = VEC_B; bias = '0;
    tick(); start = 1'b0;
    chk("s6.busy", 32'(busy), 32'd1);
    chk("s6.prep_valid", 32'(out_valid), 32'd0);
    tick(); chk_out("s5.b0", 1'b1, B0, 1'b0);
    tick(); chk_out("s5.b1", 1'b1, B1, 1'b0);
    tick(); chk_out("s5.b2", 1'b1, B2, 1'b1);
    tick(); chk_out("s5.end", 1'b0, 8'h00, 1'b0);
    chk("s5.busy_end", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
